// File: rtl/tx_mqam_pkg.sv
// Shared encodings, Gray level tables and PRBS constants for the M-QAM transmitter.
`timescale 1ns/1ps
package tx_mqam_pkg;

    typedef enum logic [1:0] {
        MODE_QPSK  = 2'd0,
        MODE_16QAM = 2'd1,
        MODE_64QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int unsigned PRBS_W      = 15;
    localparam int unsigned PRBS_TAP_HI = 14;
    localparam int unsigned PRBS_TAP_LO = 13;
    localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 15'h7FFF;

    localparam int unsigned COLL_W = 6;
    localparam int unsigned LVL_W  = 4;

    localparam logic [2:0] BITS_PER_SYM [0:3] = '{3'd2, 3'd4, 3'd6, 3'd2};

    localparam logic signed [LVL_W-1:0] GRAY2_LVL [0:1] = '{-4'sd1, 4'sd1};
    localparam logic signed [LVL_W-1:0] GRAY4_LVL [0:3] = '{-4'sd3, -4'sd1, 4'sd3, 4'sd1};
    localparam logic signed [LVL_W-1:0] GRAY8_LVL [0:7] =
        '{-4'sd7, -4'sd5, -4'sd1, -4'sd3, 4'sd7, 4'sd5, 4'sd1, 4'sd3};
    localparam logic signed [LVL_W-1:0] MODE_MULT [0:3] = '{4'sd4, 4'sd2, 4'sd1, 4'sd4};

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic [COLL_W-1:0] bits;
    } sym_t;

    function automatic mode_e sanitize_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_QPSK : mode_e'(m);
    endfunction

    // Level times mode multiplier, in units of D; always within -7..+7.
    function automatic logic signed [LVL_W-1:0] axis_level(input mode_e m,
                                                           input logic [COLL_W-1:0] bits,
                                                           input logic q_axis);
        logic signed [LVL_W-1:0] g;
        case (m)
            MODE_16QAM: g = GRAY4_LVL[q_axis ? bits[1:0] : bits[3:2]];
            MODE_64QAM: g = GRAY8_LVL[q_axis ? bits[2:0] : bits[5:3]];
            default:    g = GRAY2_LVL[q_axis ? bits[0] : bits[1]];
        endcase
        return 4'(g * MODE_MULT[m]);
    endfunction

endpackage

// File: rtl/transmit_mqam_prbs15.sv
// PRBS-15 (x^15+x^14+1) generator; bit_c is the bit produced by the next advance.
`timescale 1ns/1ps
module prbs15_gen
    import tx_mqam_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic [PRBS_W-1:0] seed_i,
    output logic              bit_c
);

    logic [PRBS_W-1:0] st_q, st_d;

    assign bit_c = st_q[PRBS_TAP_HI] ^ st_q[PRBS_TAP_LO];

    always_comb begin
        st_d = st_q;
        if (advance_i) begin
            st_d = {st_q[PRBS_W-2:0], bit_c};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= seed_i;
        end else begin
            st_q <= st_d;
        end
    end

endmodule

// File: rtl/transmit_mqam.sv
// M-QAM symbol mapper with fs/4 digital upconversion driving an offset-binary DAC.
`timescale 1ns/1ps
module transmit_mqam
    import tx_mqam_pkg::*;
#(
    parameter int unsigned       BIT_DAC   = 14,
    parameter int unsigned       SPS       = 8,
    parameter logic [PRBS_W-1:0] PRBS_SEED = PRBS_SEED_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               EN,
    input  logic [1:0]         MODE,
    output logic [BIT_DAC-1:0] DAC_OUT,
    output logic               SYM_STROBE,
    output logic               PLL_OUT_DA,
    output logic               DA_WRTA,
    output logic               DA_MODE
);

    localparam int unsigned SW = $clog2(SPS);
    localparam logic [BIT_DAC-1:0] MIDSCALE = {1'b1, {(BIT_DAC-1){1'b0}}};

    logic [SW-1:0]      s_q, s_d;
    mode_e              mode_q, mode_d;
    logic [COLL_W-1:0]  coll_q, coll_d;
    sym_t               sym_q, sym_d;
    logic [BIT_DAC-1:0] dac_q, dac_d;
    logic               strobe_q, strobe_d;
    logic               advance;
    logic               prbs_bit;
    logic [BIT_DAC-1:0] amp_i, amp_q, samp;

    prbs15_gen u_prbs (
        .clk_i     (CLOCK_50),
        .rst_i     (RESET),
        .advance_i (advance),
        .seed_i    (PRBS_SEED),
        .bit_c     (prbs_bit)
    );

    // Counter, bit collection, symbol load and upconverted sample for the next DAC word.
    always_comb begin
        s_d      = s_q;
        mode_d   = mode_q;
        coll_d   = coll_q;
        sym_d    = sym_q;
        dac_d    = MIDSCALE;
        strobe_d = 1'b0;
        advance  = 1'b0;
        amp_i    = {axis_level(sym_q.mode, sym_q.bits, 1'b0), {(BIT_DAC-LVL_W){1'b0}}};
        amp_q    = {axis_level(sym_q.mode, sym_q.bits, 1'b1), {(BIT_DAC-LVL_W){1'b0}}};
        case (s_q[1:0])
            2'd0:    samp = amp_i;
            2'd1:    samp = -amp_q;
            2'd2:    samp = -amp_i;
            default: samp = amp_q;
        endcase

        if (EN) begin
            s_d = (s_q == SW'(SPS-1)) ? '0 : s_q + SW'(1);
            if (s_q == '0) begin
                mode_d = sanitize_mode(MODE);
            end
            // s<2 always advances, so the previous period's k is safe at s=0.
            advance = int'(s_q) < int'(BITS_PER_SYM[mode_q]);
            if (advance) begin
                coll_d = {coll_q[COLL_W-2:0], prbs_bit};
            end
            if (s_q == SW'(SPS-1)) begin
                sym_d = '{valid: 1'b1, mode: mode_q, bits: coll_q};
            end
            if (sym_q.valid) begin
                dac_d    = samp + MIDSCALE;
                strobe_d = (s_q == '0);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s_q      <= '0;
            mode_q   <= MODE_QPSK;
            coll_q   <= '0;
            sym_q    <= '0;
            dac_q    <= MIDSCALE;
            strobe_q <= 1'b0;
        end else begin
            s_q      <= s_d;
            mode_q   <= mode_d;
            coll_q   <= coll_d;
            sym_q    <= sym_d;
            dac_q    <= dac_d;
            strobe_q <= strobe_d;
        end
    end

    assign DAC_OUT    = dac_q;
    assign SYM_STROBE = strobe_q;
    assign PLL_OUT_DA = CLOCK_50;
    assign DA_WRTA    = CLOCK_50;
    assign DA_MODE    = 1'b1;

endmodule

// File: tb/tb_transmit_mqam.sv
// Self-checking bench for transmit_mqam: fixed vectors, corner sequences and a PRBS-driven reference model.
`timescale 1ns/1ps
module tb_transmit_mqam;

    localparam int SPS  = 8;
    localparam int MID  = 8192;
    localparam int DSC  = 1024;
    localparam int NBIT = 8192;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic        EN;
    logic [1:0]  MODE;
    logic [13:0] DAC_OUT;
    logic        SYM_STROBE;
    logic        PLL_OUT_DA;
    logic        DA_WRTA;
    logic        DA_MODE;

    transmit_mqam dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .EN         (EN),
        .MODE       (MODE),
        .DAC_OUT    (DAC_OUT),
        .SYM_STROBE (SYM_STROBE),
        .PLL_OUT_DA (PLL_OUT_DA),
        .DA_WRTA    (DA_WRTA),
        .DA_MODE    (DA_MODE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: PRBS bit stream as an array, symbols decoded arithmetically.
    int prbs_bits [NBIT];
    int m_s, m_pmode, m_bidx, m_pstart, m_I, m_Q;
    bit m_valid;
    int exp_dac;
    bit exp_stb;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        int         dac;
        logic       stb;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode_axis(input int start, input int nb, input int mult);
        int f, b;
        f = 0;
        for (int j = 0; j < nb; j++) begin
            f = f * 2 + ((start + j < NBIT) ? prbs_bits[start + j] : 0);
        end
        b = f ^ (f >> 1) ^ (f >> 2);
        return (2 * b - ((1 << nb) - 1)) * mult * DSC;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [1:0] md);
        int k, smp;
        if (r) begin
            m_s = 0; m_pmode = 0; m_bidx = 0; m_pstart = 0; m_valid = 0;
            m_I = 0; m_Q = 0;
            exp_dac = MID; exp_stb = 0;
        end else if (e) begin
            if (m_valid) begin
                case (m_s % 4)
                    0:       smp = m_I;
                    1:       smp = -m_Q;
                    2:       smp = -m_I;
                    default: smp = m_Q;
                endcase
                exp_dac = MID + smp;
                exp_stb = (m_s == 0);
            end else begin
                exp_dac = MID; exp_stb = 0;
            end
            if (m_s == 0) begin
                m_pmode  = (md == 2'd3) ? 0 : int'(md);
                m_pstart = m_bidx;
            end
            k = 2 * (m_pmode + 1);
            if (m_s < k) m_bidx++;
            if (m_s == SPS - 1) begin
                m_I = decode_axis(m_pstart, m_pmode + 1, 4 >> m_pmode);
                m_Q = decode_axis(m_pstart + m_pmode + 1, m_pmode + 1, 4 >> m_pmode);
                m_valid = 1;
            end
            m_s = (m_s + 1) % SPS;
        end else begin
            exp_dac = MID; exp_stb = 0;
        end
    endtask

    // Drive inputs after a falling edge, let one rising edge take them, land on the next falling edge.
    task automatic step(input logic r, input logic e, input logic [1:0] md, input bit chk);
        RESET = r; EN = e; MODE = md;
        model_step(r, e, md);
        @(negedge CLOCK_50);
        if (chk) begin
            check("model_dac", int'(DAC_OUT), exp_dac);
            check("model_stb", int'(SYM_STROBE), int'(exp_stb));
        end
    endtask

    task automatic add_first_symbol(input logic [1:0] md, input int lo, input int hi);
        tbl.push_back('{1'b1, 1'b1, md, MID, 1'b0});
        for (int i = 0; i < SPS; i++) tbl.push_back('{1'b0, 1'b1, md, MID, 1'b0});
        for (int i = 0; i < SPS; i++) begin
            case (i % 4)
                0, 3:    tbl.push_back('{1'b0, 1'b1, md, lo, (i == 0)});
                default: tbl.push_back('{1'b0, 1'b1, md, hi, 1'b0});
            endcase
        end
    endtask

    initial begin
        logic [14:0] st;
        int v, in16;
        st = 15'h7FFF;
        for (int i = 0; i < NBIT; i++) begin
            logic nb;
            nb = st[14] ^ st[13];
            st = {st[13:0], nb};
            prbs_bits[i] = int'(nb);
        end

        RESET = 1'b1; EN = 1'b0; MODE = 2'd0;
        model_step(1'b1, 1'b0, 2'd0);
        @(negedge CLOCK_50);

        check("da_mode", int'(DA_MODE), 1);
        check("pll_out_low", int'(PLL_OUT_DA), 0);
        check("wrta_low", int'(DA_WRTA), 0);

        // Power-on sequences for 64QAM and QPSK first symbols.
        add_first_symbol(2'd2, 1024, 15360);
        add_first_symbol(2'd0, 4096, 12288);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].mode, 1'b0);
            check($sformatf("tbl%0d_dac", i), int'(DAC_OUT), tbl[i].dac);
            check($sformatf("tbl%0d_stb", i), int'(SYM_STROBE), int'(tbl[i].stb));
        end

        // QPSK run of 256 symbols against the model.
        step(1'b1, 1'b1, 2'd0, 1'b1);
        for (int n = 0; n < 257 * SPS + 1; n++) step(1'b0, 1'b1, 2'd0, 1'b1);

        // 16QAM -> 64QAM switched at s=3 of period 1.
        step(1'b1, 1'b1, 2'd1, 1'b1);
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b1, (n < 11) ? 2'd1 : 2'd2, 1'b1);
            v = int'(DAC_OUT);
            if (n >= 11 && n < 24) begin
                in16 = (v == 2048 || v == 6144 || v == 10240 || v == 14336) ? 1 : 0;
                check("q16_hold", in16, 1);
            end else if (n >= 24 && n < 32) begin
                check("q64_level", ((v % DSC) == 0 && ((v / DSC) % 2) == 1) ? 1 : 0, 1);
            end
        end

        // EN dropped for 5 cycles at s=5 of period 1.
        step(1'b1, 1'b1, 2'd2, 1'b1);
        for (int n = 0; n < 13; n++) step(1'b0, 1'b1, 2'd2, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 1'b0, 2'd2, 1'b1);
            check("en_low_mid", int'(DAC_OUT), MID);
            check("en_low_stb", int'(SYM_STROBE), 0);
        end
        for (int n = 0; n < 40; n++) step(1'b0, 1'b1, 2'd2, 1'b1);

        // Reset pulsed at s=4 of symbol 10.
        step(1'b1, 1'b1, 2'd0, 1'b1);
        for (int n = 0; n < 84; n++) step(1'b0, 1'b1, 2'd0, 1'b1);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        check("midrst_dac", int'(DAC_OUT), MID);
        check("midrst_stb", int'(SYM_STROBE), 0);
        for (int n = 0; n < 120; n++) step(1'b0, 1'b1, 2'd0, 1'b1);

        // Random enable, mode and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 2'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/transmit_mqam.md
TRANSMIT_MQAM -- requirements
Module: transmit_mqam

Interface
REQ-001 SHALL have parameter BIT_DAC, 14, DAC code width (>=8).
REQ-002 SHALL have parameter SPS, 8, samples per symbol (multiple of 4, >=8).
REQ-003 SHALL have parameter PRBS_SEED, 15'h7FFF, non-zero PRBS-15 reset state.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock, rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port EN  in  1  transmit enable.
REQ-007 SHALL have port MODE  in  2  0=QPSK, 1=16QAM, 2=64QAM, 3=reserved (treated as QPSK).
REQ-008 SHALL have port DAC_OUT  out  BIT_DAC  offset-binary sample, registered.
REQ-009 SHALL have port SYM_STROBE  out  1  one-cycle pulse marking a new symbol's first sample on DAC_OUT.
REQ-010 SHALL have ports PLL_OUT_DA and DA_WRTA  out  1  each a direct forward of CLOCK_50, and DA_MODE  out  1  constant 1.

Function
REQ-011 Sample counter s SHALL count 0..SPS-1 while EN=1, wrapping to 0, and SHALL hold while EN=0.
REQ-012 MODE SHALL be sampled into mode_q only in cycles with s=0 and EN=1; it fixes k = 2/4/6 bits per symbol for that symbol period.
REQ-013 PRBS-15 (x^15+x^14+1): new=st[14]^st[13], st<={st[13:0],new}, output bit=new; it SHALL advance only in cycles with EN=1 and s<k.
REQ-014 The k PRBS bits of a period SHALL shift MSB-first into a collector; the first k/2 bits form the I field, the last k/2 the Q field.
REQ-015 At s=SPS-1 with EN=1, the collector and mode_q SHALL load the symbol register; all other cycles hold it.
REQ-016 Per-axis Gray level L: QPSK 0->-1, 1->+1; 16QAM 00->-3, 01->-1, 11->+1, 10->+3; 64QAM 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
REQ-017 Axis amplitude A = L*M*D, D=2^(BIT_DAC-4), M=4 QPSK, 2 16QAM, 1 64QAM; |A| <= 7D, never overflows.
REQ-018 fs/4 upconversion by phase p=s mod 4 of the cycle the sample is produced: p0 +I, p1 -Q, p2 -I, p3 +Q.
REQ-019 DAC_OUT SHALL equal signed sample + 2^(BIT_DAC-1), registered one cycle after the producing cycle.
REQ-020 SYM_STROBE SHALL be high exactly in the cycle DAC_OUT carries the p0 sample of a newly loaded symbol.
REQ-021 While EN=0, DAC_OUT SHALL be midscale 2^(BIT_DAC-1) one cycle later and SYM_STROBE 0; on EN re-assertion output resumes at the held s with unchanged symbol and PRBS state.
REQ-022 With EN high from reset release, the first symbol's p0 sample SHALL appear on DAC_OUT SPS+1 cycles after RESET deasserts; samples before it are midscale.
REQ-023 A MODE change mid-period SHALL affect only the next symbol period; in-flight symbol keeps its mode.

Reset
REQ-024 RESET=1 at a clock edge SHALL set s=0, PRBS state=PRBS_SEED, collector=0, symbol register empty (output midscale), mode_q=QPSK, DAC_OUT=2^(BIT_DAC-1), SYM_STROBE=0.
REQ-025 RESET SHALL override EN and take effect mid-symbol, discarding partial collection.

Structure
REQ-026 Package tx_mqam_pkg SHALL hold MODE encodings, bits-per-symbol table, Gray level tables, per-mode multiplier M, PRBS polynomial and default seed.
REQ-027 PRBS generator SHALL be sub-module prbs15_gen (ports: clock, reset, advance, seed, bit); mapper, counter and upconverter stay in transmit_mqam.

Verification (BIT_DAC=14, SPS=8, D=1024, midscale 8192)
REQ-028 Reset, EN=1, MODE=2 -> first 8 samples 8192; first symbol (bits 000000) DAC_OUT 1024, 15360, 15360, 1024, repeated twice, SYM_STROBE on the first.
REQ-029 Reset, EN=1, MODE=0 -> first symbol (bits 00) DAC_OUT 4096, 12288, 12288, 4096; subsequent symbols match a PRBS-15 reference model bit-exactly for 256 symbols.
REQ-030 MODE=1 to 2 switched at s=3 -> current and next symbol stay 16QAM levels (from {2048,6144,10240,14336}); mode change visible from the symbol loaded one period later.
REQ-031 EN dropped for 5 cycles at s=5 -> DAC_OUT 8192 for those 5 cycles, then resumes with the s=5 sample of the same symbol; PRBS sequence unbroken.
REQ-032 RESET pulsed at s=4 of symbol 10 -> next cycle DAC_OUT=8192, SYM_STROBE=0; output sequence then identical to that after power-on reset.
